// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32/RV64 integer core: FETCH -> EXEC -> (MEM) -> FETCH, with halt on ebreak
// or any unsupported encoding. Owns the PC and the architectural register file.
module rv_multicycle_core #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_valid,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_valid,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wmask,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);
  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(NB);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [XLEN-1:0]   regs [0:31];
  logic [XLEN-1:0]   mem_addr, mem_wdata;
  logic [NB-1:0]     mem_wmask;
  logic              mem_we;
  logic [4:0]        mem_rd;
  logic [2:0]        mem_f3;

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        rd;
  logic [XLEN-1:0]   rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j, ea, pc4;
  logic              op_ok, is_ld, is_st, is_ebreak, wr_en;
  logic [XLEN-1:0]   wr_data, npc, ld_data;
  logic [NB-1:0]     st_mask;

  assign opcode    = ir[6:0];
  assign f3        = ir[14:12];
  assign f7        = ir[31:25];
  assign rd        = ir[11:7];
  // regs[0] is reset to zero and never written, so x0 reads as 0
  assign rs1v      = regs[ir[19:15]];
  assign rs2v      = regs[ir[24:20]];
  assign imm_i     = XLEN'($signed(ir[31:20]));
  assign imm_s     = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_b     = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign imm_u     = XLEN'($signed({ir[31:12], 12'b0}));
  assign imm_j     = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
  assign pc4       = pc + XLEN'(4);
  assign ea        = rs1v + ((opcode == 7'b0100011) ? imm_s : imm_i);
  assign is_ebreak = (ir == 32'h0010_0073);
  assign st_mask   = (f3 == 3'b011) ? '1 : (NB'(4'hF) << ea[AW-1:0]);

  always_comb begin
    op_ok   = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    npc     = pc4;
    case (opcode)
      7'b0010011: if (f3 == 3'b000) begin
        op_ok = 1'b1; wr_en = 1'b1; wr_data = rs1v + imm_i;
      end
      7'b0110011: if (f3 == 3'b000 && f7 == 7'b0000000) begin
        op_ok = 1'b1; wr_en = 1'b1; wr_data = rs1v + rs2v;
      end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
        op_ok = 1'b1; wr_en = 1'b1; wr_data = rs1v - rs2v;
      end
      7'b0110111: begin op_ok = 1'b1; wr_en = 1'b1; wr_data = imm_u; end
      7'b0010111: begin op_ok = 1'b1; wr_en = 1'b1; wr_data = pc + imm_u; end
      7'b1101111: begin
        op_ok = 1'b1; wr_en = 1'b1; wr_data = pc4; npc = pc + imm_j;
      end
      7'b1100111: if (f3 == 3'b000) begin
        op_ok = 1'b1; wr_en = 1'b1; wr_data = pc4;
        npc = (rs1v + imm_i) & ~XLEN'(1);
      end
      7'b1100011: begin
        if (f3 == 3'b000) begin
          op_ok = 1'b1;
          if (rs1v == rs2v) npc = pc + imm_b;
        end else if (f3 == 3'b001) begin
          op_ok = 1'b1;
          if (rs1v != rs2v) npc = pc + imm_b;
        end
      end
      7'b0000011: is_ld = (f3 == 3'b010) || (XLEN == 64 && (f3 == 3'b110 || f3 == 3'b011));
      7'b0100011: is_st = (f3 == 3'b010) || (XLEN == 64 && f3 == 3'b011);
      default: ;
    endcase
  end

  always_comb begin
    case (mem_f3)
      3'b010:  ld_data = XLEN'($signed(dmem_rdata[31:0]));
      3'b110:  ld_data = XLEN'(dmem_rdata[31:0]);
      default: ld_data = dmem_rdata;
    endcase
  end

  assign imem_valid = (state == S_FETCH) && !rst;
  assign imem_addr  = pc;
  assign dmem_valid = (state == S_MEM) && !rst;
  assign dmem_we    = mem_we;
  assign dmem_addr  = mem_addr;
  assign dmem_wdata = mem_wdata;
  assign dmem_wmask = mem_wmask;
  assign retire     = (state == S_EXEC && op_ok) || (state == S_MEM && dmem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC[XLEN-1:0];
      ir        <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      mem_we    <= 1'b0;
      mem_rd    <= '0;
      mem_f3    <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) begin
          ir    <= imem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (op_ok) begin
            if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
            pc    <= npc;
            state <= S_FETCH;
          end else if (is_ld || is_st) begin
            mem_addr  <= ea;
            mem_we    <= is_st;
            mem_wdata <= rs2v;
            mem_wmask <= is_st ? st_mask : '0;
            mem_rd    <= rd;
            mem_f3    <= f3;
            state     <= S_MEM;
          end else begin
            halted  <= 1'b1;
            illegal <= !is_ebreak;
            state   <= S_HALT;
          end
        end
        S_MEM: if (dmem_ready) begin
          if (!mem_we && mem_rd != 5'd0) regs[mem_rd] <= ld_data;
          pc    <= pc4;
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core (XLEN=64): small instruction ROM, scripted memory
// handshakes, and hand-computed expected register/port values.
module tb_rv_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_valid, imem_ready;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_valid, dmem_we, dmem_ready;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [7:0]  dmem_wmask;
  logic        retire, halted, illegal;

  logic [31:0] rom [0:15];
  int          errs = 0;
  int          checks = 0;

  rv_multicycle_core #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Outside the 16-word ROM window every fetch returns ebreak
  always_comb begin
    logic [63:0] off;
    off = imem_addr - 64'h8000_0000;
    imem_rdata = (off < 64'd64) ? rom[off[5:2]] : 32'h0010_0073;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) rom[i] = 32'h0010_0073;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 64'h1234_5678_8000_0001;

    // A: addi / auipc / lui / sd with wait states / beq backwards
    restart();
    rom[0] = 32'h0050_0093;  // addi x1,x0,5
    rom[1] = 32'h0000_1197;  // auipc x3,1
    rom[2] = 32'h8000_0137;  // lui x2,0x80000
    rom[3] = 32'h0010_3423;  // sd x1,8(x0)
    rom[4] = 32'hFE00_0CE3;  // beq x0,x0,-8
    tick();
    chk("rst_imem_valid", 64'(imem_valid), 64'd0);
    chk("rst_dmem_valid", 64'(dmem_valid), 64'd0);
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_status", {61'd0, retire, halted, illegal}, 64'd0);
    release_rst();
    chk("fetch0_valid", 64'(imem_valid), 64'd1);
    chk("fetch0_addr", imem_addr, 64'h8000_0000);
    tick();
    chk("addi_retire", 64'(retire), 64'd1);
    tick();
    chk("addi_pc", pc, 64'h8000_0004);
    chk("addi_x1", dut.regs[1], 64'd5);
    chk("addi_retire_low", 64'(retire), 64'd0);
    tick(); tick();
    chk("auipc_x3", dut.regs[3], 64'h8000_1004);
    tick(); tick();
    chk("lui_x2", dut.regs[2], 64'hFFFF_FFFF_8000_0000);
    tick();
    chk("sd_exec_no_retire", 64'(retire), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("sd_valid", 64'(dmem_valid), 64'd1);
      chk("sd_we", 64'(dmem_we), 64'd1);
      chk("sd_addr", dmem_addr, 64'd8);
      chk("sd_wdata", dmem_wdata, 64'd5);
      chk("sd_wmask", 64'(dmem_wmask), 64'hFF);
      chk("sd_wait_retire", 64'(retire), 64'd0);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("sd_retire", 64'(retire), 64'd1);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("sd_pc", pc, 64'h8000_0010);
    chk("sd_done_valid", 64'(dmem_valid), 64'd0);
    tick(); tick();
    chk("beq_target", imem_addr, 64'h8000_0008);

    // B: sub, taken bne, jalr with rd==rs1, then ebreak at the jalr target
    restart();
    rom[0] = 32'h0000_0097;  // auipc x1,0
    rom[1] = 32'h1000_8093;  // addi x1,x1,256
    rom[2] = 32'h4010_0133;  // sub x2,x0,x1
    rom[3] = 32'h0011_1463;  // bne x2,x1,+8
    rom[4] = 32'h0000_0000;  // skipped
    rom[5] = 32'h0030_80E7;  // jalr x1,x1,3
    release_rst();
    tick(); tick();
    tick(); tick();
    chk("addi_x1_b", dut.regs[1], 64'h8000_0100);
    tick(); tick();
    chk("sub_x2", dut.regs[2], 64'hFFFF_FFFF_7FFF_FF00);
    tick(); tick();
    chk("bne_taken_pc", pc, 64'h8000_0014);
    tick(); tick();
    chk("jalr_pc", pc, 64'h8000_0102);
    chk("jalr_x1", dut.regs[1], 64'h8000_0018);
    tick();
    chk("ebreak_no_retire", 64'(retire), 64'd0);
    tick();
    chk("ebreak_halted", 64'(halted), 64'd1);
    chk("ebreak_illegal", 64'(illegal), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("halt_no_fetch", 64'(imem_valid), 64'd0);
      chk("halt_pc", pc, 64'h8000_0102);
      tick();
    end

    // C: all-zero word is illegal
    restart();
    rom[0] = 32'h0000_0000;
    release_rst();
    chk("reset_clears_halt", 64'(halted), 64'd0);
    tick();
    chk("illegal_no_retire", 64'(retire), 64'd0);
    tick();
    chk("illegal_halted", 64'(halted), 64'd1);
    chk("illegal_flag", 64'(illegal), 64'd1);
    chk("illegal_no_fetch", 64'(imem_valid), 64'd0);

    // D: fetch stall, lw sign extension, reset during a stalled load
    restart();
    rom[0] = 32'h0050_0093;  // addi x1,x0,5
    rom[1] = 32'h0000_2103;  // lw x2,0(x0)
    rom[2] = 32'h0000_2103;  // lw x2,0(x0)
    imem_ready = 1'b0;
    release_rst();
    tick();
    chk("fetch_stall_addr", imem_addr, 64'h8000_0000);
    chk("fetch_stall_valid", 64'(imem_valid), 64'd1);
    chk("fetch_stall_retire", 64'(retire), 64'd0);
    imem_ready = 1'b1;
    tick(); tick();
    chk("addi_x1_d", dut.regs[1], 64'd5);
    tick(); tick();
    chk("lw_valid", 64'(dmem_valid), 64'd1);
    chk("lw_we", 64'(dmem_we), 64'd0);
    chk("lw_addr", dmem_addr, 64'd0);
    dmem_ready = 1'b1;
    #1;
    chk("lw_retire", 64'(retire), 64'd1);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("lw_x2", dut.regs[2], 64'hFFFF_FFFF_8000_0001);
    tick(); tick();
    chk("lw2_valid", 64'(dmem_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_dmem_valid", 64'(dmem_valid), 64'd0);
    chk("rst_mid_imem_valid", 64'(imem_valid), 64'd0);
    chk("rst_mid_pc", pc, 64'h8000_0000);
    chk("rst_mid_x1", dut.regs[1], 64'd0);
    tick();
    release_rst();
    chk("restart_valid", 64'(imem_valid), 64'd1);
    chk("restart_addr", imem_addr, 64'h8000_0000);
    tick();
    chk("restart_retire", 64'(retire), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
